// File: rtl/creator_clk_pkg.sv
// Shared types for the clock-enable generator.
// Sequencer encoding is visible through the status readback.
package creator_clk_pkg;

  localparam int SEQ_STATE_W = 2;

  typedef enum logic [SEQ_STATE_W-1:0] {
    S_RESET     = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_HOLD      = 2'd2,
    S_RUN       = 2'd3
  } seq_state_t;

endpackage

// File: rtl/creator_clk_ch.sv
// One programmable-divide strobe channel.
// Period is D+1 cycles; new divisors only land on a wrap.
module creator_clk_ch #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             we,
  input  logic [DIV_W-1:0] data,
  output logic             tick,
  output logic             tick_n,
  output logic             sq
);

  localparam int CW = DIV_W + 1;

  logic [DIV_W-1:0] shadow;
  logic [DIV_W-1:0] active;
  logic [DIV_W-1:0] shadow_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    p;
  logic [CW-1:0]    last;
  logic [CW-1:0]    half_m1;
  logic [CW-1:0]    sq_lim;
  logic             wrap;

  // Period arithmetic is one bit wider so D = all-ones cannot overflow.
  always_comb begin
    shadow_nxt = we ? data : shadow;
    p          = {1'b0, active} + CW'(1);
    last       = {1'b0, active};
    half_m1    = (p >> 1) - CW'(1);
    sq_lim     = (p + CW'(1)) >> 1;
    wrap       = (cnt == last);
  end

  // Counter, divisor reload and registered strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
      active <= '0;
      cnt    <= '0;
      tick   <= 1'b0;
      tick_n <= 1'b0;
      sq     <= 1'b0;
    end else begin
      shadow <= shadow_nxt;
      if (!run) begin
        active <= shadow_nxt;
        cnt    <= '0;
        tick   <= 1'b0;
        tick_n <= 1'b0;
        sq     <= 1'b0;
      end else begin
        if (wrap) begin
          active <= shadow_nxt;
          cnt    <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
        tick   <= wrap;
        tick_n <= (active == '0) ? wrap : (cnt == half_m1);
        sq     <= (cnt < sq_lim);
      end
    end
  end

endmodule

// File: rtl/creator_clk_gen.sv
// Clock-enable generator with DCM-lock reset sequencer.
// Channels only run once lock has been stable for the hold time.
module creator_clk_gen
  import creator_clk_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int DIV_W       = 16,
  parameter int HOLD_W      = 10,
  parameter int SYNC_STAGES = 2,
  localparam int SEL_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dcm_locked,
  input  logic                   div_we,
  input  logic [SEL_W-1:0]       div_sel,
  input  logic [DIV_W-1:0]       div_data,
  input  logic [N_CH-1:0]        ch_en,
  output logic [N_CH-1:0]        tick,
  output logic [N_CH-1:0]        tick_n,
  output logic [N_CH-1:0]        sq,
  output logic                   sys_rst,
  output logic [SEQ_STATE_W-1:0] seq_state
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   locked_s;
  seq_state_t             state;
  logic [HOLD_W-1:0]      hold;
  logic                   run_all;

  assign locked_s  = sync[SYNC_STAGES-1];
  assign seq_state = state;

  // Gating on locked_s too lets channels drop with sys_rst on lock loss.
  assign run_all = (state == S_RUN) && locked_s;

  // Bring the asynchronous DCM lock into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) sync <= '0;
    else     sync <= {sync[SYNC_STAGES-2:0], dcm_locked};
  end

  // Reset sequencer; sys_rst follows the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_RESET;
      hold    <= '0;
      sys_rst <= 1'b1;
    end else begin
      unique case (state)
        S_RESET: begin
          state   <= S_WAIT_LOCK;
          hold    <= '0;
          sys_rst <= 1'b1;
        end
        S_WAIT_LOCK: begin
          hold    <= '0;
          sys_rst <= 1'b1;
          if (locked_s) state <= S_HOLD;
        end
        S_HOLD: begin
          sys_rst <= 1'b1;
          if (!locked_s) begin
            state <= S_WAIT_LOCK;
            hold  <= '0;
          end else if (&hold) begin
            state   <= S_RUN;
            sys_rst <= 1'b0;
          end else begin
            hold <= hold + HOLD_W'(1);
          end
        end
        S_RUN: begin
          if (!locked_s) begin
            state   <= S_WAIT_LOCK;
            sys_rst <= 1'b1;
          end else begin
            sys_rst <= 1'b0;
          end
        end
        default: begin
          state   <= S_RESET;
          hold    <= '0;
          sys_rst <= 1'b1;
        end
      endcase
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic ch_we;
    assign ch_we = div_we && (32'(div_sel) == i);

    creator_clk_ch #(
      .DIV_W (DIV_W)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .run    (run_all && ch_en[i]),
      .we     (ch_we),
      .data   (div_data),
      .tick   (tick[i]),
      .tick_n (tick_n[i]),
      .sq     (sq[i])
    );
  end

endmodule
